// File: rtl/bc_hit_tagger.sv
// bc_hit_tagger: tags digitizer hits with the current 12-bit bunch crossing
// number, packs them into 32-bit words and buffers them in a first-word-
// fall-through FIFO toward a valid/ready readout link.
//
// Optional feature macro: BC_HIT_TAGGER_ORBIT_EN
//   defined   -> 4-bit orbit counter (incremented on BC wrap FFF->000) in TAG
//   undefined -> no orbit logic, TAG = 4'h0
//
// Ports:
//   CLK        clock, shared with the bunch counter
//   RST        synchronous active-high reset
//   BC         current bunch number (same clock domain)
//   HIT_VALID  hit strobe, at most one hit per cycle
//   HIT_CH     hit channel
//   HIT_ADC    hit amplitude
//   OUT_VALID  FIFO non-empty, OUT_DATA valid
//   OUT_READY  consumer accepts the head word this cycle
//   OUT_DATA   {CH[3:0], BC[11:0], ADC[11:0], TAG[3:0]}
//   FILL       words currently stored
//   DROP_CNT   hits lost to a full FIFO, saturating
module bc_hit_tagger #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [11:0]   BC,
  input  logic          HIT_VALID,
  input  logic [3:0]    HIT_CH,
  input  logic [11:0]   HIT_ADC,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [31:0]   OUT_DATA,
  output logic [AW:0]   FILL,
  output logic [15:0]   DROP_CNT
);

  localparam int unsigned DW       = 32;
  localparam int unsigned CNT_W    = 16;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // FIFO state
  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic [3:0]       tag_c;
  logic [DW-1:0]    wdata_c;

`ifdef BC_HIT_TAGGER_ORBIT_EN
  logic [11:0] prev_bc_q, prev_bc_d;
  logic [3:0]  orbit_q, orbit_d;

  // Orbit advances on the FFF->000 wrap; a hit on that cycle sees the new value
  always_comb begin
    prev_bc_d = BC;
    orbit_d   = orbit_q;
    if ((BC == 12'h000) && (prev_bc_q == 12'hFFF)) begin
      orbit_d = orbit_q + 4'd1;
    end
    tag_c = orbit_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_bc_q <= 12'h000;
      orbit_q   <= 4'h0;
    end else begin
      prev_bc_q <= prev_bc_d;
      orbit_q   <= orbit_d;
    end
  end
`else
  always_comb begin
    tag_c = 4'h0;
  end
`endif

  // Push/pop decision, pointer, fill and drop-counter next state
  always_comb begin
    pop_c       = out_valid_q && OUT_READY;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push_c      = HIT_VALID && ((fill_q != FULL_LVL) || pop_c);
    drop_c      = HIT_VALID && !push_c;
    wdata_c     = {HIT_CH, BC, HIT_ADC, tag_c};

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    drop_cnt_d  = drop_cnt_q;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase

    if (drop_c && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    // Registered so OUT_READY never reaches OUT_VALID combinationally
    out_valid_d = (fill_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible while FILL > 0
  always_ff @(posedge CLK) begin
    if (push_c && !RST) begin
      mem_q[wr_ptr_q] <= wdata_c;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = mem_q[rd_ptr_q];
  assign FILL      = fill_q;
  assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_bc_hit_tagger.sv
// Directed self-checking bench for bc_hit_tagger (DEPTH=16).
module tb_bc_hit_tagger;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic        CLK;
  logic        RST;
  logic [11:0] BC;
  logic        HIT_VALID;
  logic [3:0]  HIT_CH;
  logic [11:0] HIT_ADC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic [AW:0] FILL;
  logic [15:0] DROP_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  bc_hit_tagger #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .BC(BC), .HIT_VALID(HIT_VALID), .HIT_CH(HIT_CH),
    .HIT_ADC(HIT_ADC), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .FILL(FILL), .DROP_CNT(DROP_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Inputs are driven and outputs sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] ch, input logic [11:0] bc,
                                     input logic [11:0] adc, input logic [3:0] tag);
    return {ch, bc, adc, tag};
  endfunction

  // Per-index hit payload used by the fill tests
  function automatic logic [31:0] hit_word(input int i);
    return mk(4'(i), 12'(12'h200 + i), 12'(12'h050 * i + 7), 4'h0);
  endfunction

  task automatic drive_hit(input int i);
    HIT_VALID = 1'b1;
    HIT_CH    = 4'(i);
    BC        = 12'(12'h200 + i);
    HIT_ADC   = 12'(12'h050 * i + 7);
  endtask

  task automatic test_reset();
    RST = 1'b1; HIT_VALID = 1'b0; OUT_READY = 1'b0; BC = '0; HIT_CH = '0; HIT_ADC = '0;
    tick(); tick();
    RST = 1'b0;
    n_checks++;
    if (FILL !== 5'd0) begin n_fail++; $display("FAIL reset_fill got %0d exp 0", FILL); end
    n_checks++;
    if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", OUT_VALID); end
    n_checks++;
    if (DROP_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d exp 0", DROP_CNT); end
  endtask

  task automatic test_single_hit();
    BC = 12'h123; HIT_CH = 4'd3; HIT_ADC = 12'hABC; HIT_VALID = 1'b1; OUT_READY = 1'b0;
    n_checks++;
    if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid got %b exp 0", OUT_VALID); end
    tick();
    HIT_VALID = 1'b0;
    n_checks++;
    if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", OUT_VALID); end
    n_checks++;
    if (OUT_DATA !== 32'h3123ABC0) begin n_fail++; $display("FAIL single_data got %h exp 3123abc0", OUT_DATA); end
    n_checks++;
    if (FILL !== 5'd1) begin n_fail++; $display("FAIL single_fill got %0d exp 1", FILL); end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    n_checks++;
    if (FILL !== 5'd0 || OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL single_drain fill=%0d valid=%b exp 0/0", FILL, OUT_VALID);
    end
  endtask

  task automatic test_overflow();
    OUT_READY = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive_hit(i);
      tick();
    end
    HIT_VALID = 1'b0;
    n_checks++;
    if (FILL !== 5'(DEPTH)) begin n_fail++; $display("FAIL ovf_fill got %0d exp %0d", FILL, DEPTH); end
    n_checks++;
    if (DROP_CNT !== 16'd3) begin n_fail++; $display("FAIL ovf_drop got %0d exp 3", DROP_CNT); end
    OUT_READY = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== hit_word(i)) begin
        n_fail++; $display("FAIL ovf_drain[%0d] got v=%b %h exp v=1 %h", i, OUT_VALID, OUT_DATA, hit_word(i));
      end
      tick();
    end
    OUT_READY = 1'b0;
    n_checks++;
    if (FILL !== 5'd0 || OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL ovf_empty fill=%0d valid=%b exp 0/0", FILL, OUT_VALID);
    end
  endtask

  task automatic test_full_simultaneous();
    OUT_READY = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_hit(i);
      tick();
    end
    drive_hit(40);
    OUT_READY = 1'b1;
    tick();
    HIT_VALID = 1'b0;
    OUT_READY = 1'b0;
    n_checks++;
    if (FILL !== 5'(DEPTH)) begin n_fail++; $display("FAIL simul_fill got %0d exp %0d", FILL, DEPTH); end
    n_checks++;
    if (DROP_CNT !== 16'd3) begin n_fail++; $display("FAIL simul_drop got %0d exp 3", DROP_CNT); end
    OUT_READY = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      logic [31:0] exp_w;
      exp_w = (i == DEPTH) ? hit_word(40) : hit_word(i);
      n_checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_w) begin
        n_fail++; $display("FAIL simul_drain[%0d] got v=%b %h exp v=1 %h", i, OUT_VALID, OUT_DATA, exp_w);
      end
      tick();
    end
    OUT_READY = 1'b0;
    n_checks++;
    if (FILL !== 5'd0) begin n_fail++; $display("FAIL simul_empty got %0d exp 0", FILL); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] held;
    logic        stall;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
    while ((sent < 10 || q.size() > 0) && cyc < 200) begin
      if (sent < 10) drive_hit(sent + 100);
      else HIT_VALID = 1'b0;
      OUT_READY = cyc[0];
      if (stall) begin
        n_checks++;
        if (OUT_DATA !== held) begin n_fail++; $display("FAIL bp_stall cyc %0d got %h exp %h", cyc, OUT_DATA, held); end
      end
      if (OUT_VALID && OUT_READY) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_dup cyc %0d got %h exp none", cyc, OUT_DATA);
        end else begin
          if (OUT_DATA !== q[0]) begin n_fail++; $display("FAIL bp_order cyc %0d got %h exp %h", cyc, OUT_DATA, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      stall = OUT_VALID && !OUT_READY;
      held  = OUT_DATA;
      if (HIT_VALID) begin
        q.push_back(hit_word(sent + 100));
        sent++;
      end
      tick();
      cyc++;
    end
    HIT_VALID = 1'b0; OUT_READY = 1'b0;
    n_checks++;
    if (got != 10 || cyc >= 200) begin n_fail++; $display("FAIL bp_count got %0d words in %0d cycles exp 10", got, cyc); end
    n_checks++;
    if (FILL !== 5'd0 || DROP_CNT !== 16'd3) begin
      n_fail++; $display("FAIL bp_final fill=%0d drop=%0d exp 0/3", FILL, DROP_CNT);
    end
  endtask

  task automatic test_reset_mid_burst();
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_hit(i);
      tick();
    end
    n_checks++;
    if (FILL !== 5'd5) begin n_fail++; $display("FAIL rstmid_pre_fill got %0d exp 5", FILL); end
    RST = 1'b1;
    drive_hit(9);
    tick();
    RST = 1'b0;
    HIT_VALID = 1'b0;
    n_checks++;
    if (FILL !== 5'd0 || OUT_VALID !== 1'b0 || DROP_CNT !== 16'd0) begin
      n_fail++; $display("FAIL rstmid fill=%0d valid=%b drop=%0d exp 0/0/0", FILL, OUT_VALID, DROP_CNT);
    end
  endtask

  task automatic test_orbit();
    logic [11:0] bcs [4];
    logic [3:0]  exp_tag [4];
    logic [3:0]  one, fifteen;
`ifdef BC_HIT_TAGGER_ORBIT_EN
    one = 4'h1; fifteen = 4'hF;
`else
    one = 4'h0; fifteen = 4'h0;
`endif
    bcs[0] = 12'hFFE; bcs[1] = 12'hFFF; bcs[2] = 12'h000; bcs[3] = 12'h001;
    exp_tag[0] = 4'h0; exp_tag[1] = 4'h0; exp_tag[2] = one; exp_tag[3] = one;
    RST = 1'b1; HIT_VALID = 1'b0; OUT_READY = 1'b0; BC = 12'h000;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      BC = bcs[i]; HIT_VALID = 1'b1; HIT_CH = 4'(i + 8); HIT_ADC = 12'(12'h300 + i);
      tick();
    end
    HIT_VALID = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_w;
      exp_w = mk(4'(i + 8), bcs[i], 12'(12'h300 + i), exp_tag[i]);
      n_checks++;
      if (OUT_DATA !== exp_w) begin n_fail++; $display("FAIL orbit_tag[%0d] got %h exp %h", i, OUT_DATA, exp_w); end
      tick();
    end
    OUT_READY = 1'b0;
    // 15 more wraps, hitting on wrap 15 (orbit F) and wrap 16 (orbit back to 0)
    for (int w = 1; w <= 15; w++) begin
      BC = 12'hFFF; HIT_VALID = 1'b0;
      tick();
      BC = 12'h000; HIT_VALID = (w >= 14); HIT_CH = 4'h5; HIT_ADC = 12'(w);
      tick();
    end
    HIT_VALID = 1'b0;
    n_checks++;
    if (OUT_DATA !== mk(4'h5, 12'h000, 12'd14, fifteen)) begin
      n_fail++; $display("FAIL orbit_wrap15 got %h exp %h", OUT_DATA, mk(4'h5, 12'h000, 12'd14, fifteen));
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    n_checks++;
    if (OUT_DATA !== mk(4'h5, 12'h000, 12'd15, 4'h0) || FILL !== 5'd1) begin
      n_fail++; $display("FAIL orbit_wrap16 got %h fill=%0d exp %h fill=1", OUT_DATA, FILL, mk(4'h5, 12'h000, 12'd15, 4'h0));
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_overflow();
    test_full_simultaneous();
    test_back_to_back();
    test_reset_mid_burst();
    test_orbit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bc_hit_tagger.md
# bc_hit_tagger

- Sits directly downstream of the bunch counter and tags digitizer hits with the current 12-bit bunch crossing (BC) number.
- Packs each tagged hit into a 32-bit word and buffers it in a first-word-fall-through FIFO toward the readout link, which uses a valid/ready handshake.
- Counts hits dropped on overflow; optionally extends the timestamp with an orbit count derived from BC wrap-around.

## Interface
Parameters:
- DEPTH, 16: FIFO depth in words. Must be a power of two, ≥ 2.
- AW, 4: log2(DEPTH).

Ports:
- CLK  in  1  clock, shared with the bunch counter.
- RST  in  1  reset, synchronous, active-high.
- BC  in  12  bunch number from the bunch counter, same clock domain.
- HIT_VALID  in  1  hit strobe; one hit per cycle maximum.
- HIT_CH  in  4  hit channel number.
- HIT_ADC  in  12  hit amplitude.
- OUT_VALID  out  1  FIFO non-empty; OUT_DATA is valid.
- OUT_READY  in  1  consumer accepts the word this cycle.
- OUT_DATA  out  32  {CH[3:0], BC[11:0], ADC[11:0], TAG[3:0]}.
- FILL  out  AW+1  number of words currently stored.
- DROP_CNT  out  16  hits lost because the FIFO was full; saturates at 16'hFFFF.

## Operation
Capture:
- A hit is sampled on the CLK edge where HIT_VALID=1.
- BC, HIT_CH and HIT_ADC are all taken from that same edge.
- No BC realignment is performed.

Push/pop rules:
- Push is accepted if FILL<DEPTH, or if FILL==DEPTH and a pop occurs in the same cycle.
- A pop occurs when OUT_VALID && OUT_READY.
- Simultaneous push and pop leaves FILL unchanged and keeps words in order.
- A rejected push increments DROP_CNT by 1. The increment is suppressed at 16'hFFFF.

Pointers and storage:
- Read and write pointers are AW bits and wrap modulo DEPTH.
- FILL is tracked explicitly. Full means FILL==DEPTH; empty means FILL==0.
- OUT_DATA = mem[rd_ptr], first-word-fall-through. It holds steady while OUT_VALID && !OUT_READY.
- OUT_DATA is don't-care when OUT_VALID=0.

Orbit tracking:
- The orbit counter is 4 bits.
- It increments on the cycle BC==12'h000 while the registered previous BC==12'hFFF.
- It wraps 4'hF→4'h0.
- A hit on the wrap cycle gets the already-incremented TAG.

Reset:
- Reset values: FILL=0, OUT_VALID=0, DROP_CNT=0, pointers=0, orbit=0, previous-BC register=0.
- Reset mid-operation discards all stored words in the same cycle. A HIT_VALID during RST is ignored and not counted as dropped.
- Because previous BC resets to 0, the first 000 seen after reset does not increment the orbit count.

## Timing
- Hit at edge n produces OUT_VALID=1 after edge n, i.e. one-cycle latency, when the FIFO was empty.
- A pop at edge n exposes the next word after edge n.
- FILL and DROP_CNT are registered and update on the same edge as the push/pop or drop.
- No combinational path from OUT_READY to OUT_VALID. OUT_READY feeds only the pointer/FILL logic.
- Sustained throughput: one word in and one word out per cycle.

## Configuration
- Macro: BC_HIT_TAGGER_ORBIT_EN.
- Defined: the orbit counter is built and TAG = orbit[3:0].
- Undefined: no orbit counter or previous-BC register is built, and TAG = 4'h0.
- All other behaviour is identical with and without the macro.

## Test plan
- Reset, then a single hit with CH=3, ADC=12'hABC at BC=12'h123, OUT_READY=0:
  - OUT_VALID rises one cycle later.
  - OUT_DATA=32'h3123ABC0 with the macro undefined.
  - FILL=1.
- Fill and overflow: push DEPTH+3 hits with OUT_READY=0.
  - FILL=DEPTH and DROP_CNT=3.
  - Draining returns the first DEPTH hits in order.
- Full and simultaneous: with FILL==DEPTH, push and pop in the same cycle.
  - FILL stays DEPTH and DROP_CNT does not change.
  - The new word appears last in the drain.
- Backpressure: toggle OUT_READY every cycle during a 10-hit burst.
  - No loss, no duplication, and OUT_DATA stable while stalled.
- Orbit, macro defined: drive BC 12'hFFE, FFF, 000, 001 and hit on each cycle.
  - TAG sequence 0,0,1,1.
  - After 16 wraps, TAG returns to 0.
- Reset mid-burst: assert RST with FILL=5 and HIT_VALID=1.
  - Next cycle FILL=0, OUT_VALID=0, DROP_CNT=0.
